// File: rtl/prime_candidate_builder.sv
// Packs the 16-bit PRNG stream into an odd, top-heavy WORDSIZE-bit prime candidate and offers it via valid/ready.
// Optional small-prime sieve (3, 5, 17) is built when SMALL_PRIME_SIEVE_EN is defined.
module prime_candidate_builder #(
   parameter int WORDSIZE = 256
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                flush,
   input  logic                enable,
   input  logic [15:0]         rand_in,
   input  logic                rand_valid,
   output logic [WORDSIZE-1:0] candidate,
   output logic                cand_valid,
   input  logic                cand_ready,
   output logic [31:0]         cand_count,
   output logic [31:0]         reject_count
);

   localparam int NWORDS = WORDSIZE / 16;
   localparam int IDX_W  = (NWORDS > 1) ? $clog2(NWORDS) : 1;

   typedef enum logic [1:0] {FILL, CHECK, OFFER} state_t;

   state_t           state;
   logic [IDX_W-1:0] idx;
   logic             capture;
   logic             last_word;
   logic [15:0]      forced_word;
   logic             sieve_reject;

   // Bit 0 makes the candidate odd; the top two bits keep p*q at full width.
   function automatic logic [15:0] force_bits(input logic [15:0] w, input logic first,
                                              input logic last);
      return w | {last, last, 13'b0, first};
   endfunction

   assign capture     = (state == FILL) && rand_valid && enable;
   assign last_word   = (idx == IDX_W'(NWORDS - 1));
   assign forced_word = force_bits(rand_in, idx == '0, last_word);

`ifdef SMALL_PRIME_SIEVE_EN
   logic [7:0]  residue;
   logic [31:0] reject_q;

   // 2^16 == 1 (mod 255), so summing bytes with end-around carry tracks candidate mod 255.
   function automatic logic [7:0] fold255(input logic [7:0] r, input logic [15:0] w);
      logic [9:0] s;
      logic [8:0] t;
      logic [7:0] u;
      s = 10'(r) + 10'(w[15:8]) + 10'(w[7:0]);
      t = 9'(s[7:0]) + 9'(s[9:8]);
      u = t[7:0] + 8'(t[8]);
      return (u == 8'hFF) ? 8'h00 : u;
   endfunction

   function automatic logic small_factor(input logic [7:0] r);
      return ((r % 8'd3) == 8'd0) || ((r % 8'd5) == 8'd0) || ((r % 8'd17) == 8'd0);
   endfunction

   assign sieve_reject = small_factor(residue);
   assign reject_count = reject_q;
`else
   assign sieve_reject = 1'b0;
   assign reject_count = '0;
`endif

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state      <= FILL;
         idx        <= '0;
         candidate  <= '0;
         cand_valid <= 1'b0;
         cand_count <= '0;
`ifdef SMALL_PRIME_SIEVE_EN
         residue    <= '0;
         reject_q   <= '0;
`endif
      end else if (flush) begin
         // Stale candidate bits are left in place; cand_valid=0 hides them.
         state      <= FILL;
         idx        <= '0;
         cand_valid <= 1'b0;
`ifdef SMALL_PRIME_SIEVE_EN
         residue    <= '0;
`endif
      end else begin
         case (state)
            FILL: begin
               if (capture) begin
                  candidate[{idx, 4'b0000} +: 16] <= forced_word;
`ifdef SMALL_PRIME_SIEVE_EN
                  residue <= fold255(residue, forced_word);
`endif
                  if (last_word) begin
                     idx   <= '0;
                     state <= CHECK;
                  end else begin
                     idx <= idx + 1'b1;
                  end
               end
            end
            CHECK: begin
               if (sieve_reject) begin
                  state <= FILL;
`ifdef SMALL_PRIME_SIEVE_EN
                  residue  <= '0;
                  reject_q <= reject_q + 32'd1;
`endif
               end else begin
                  state      <= OFFER;
                  cand_valid <= 1'b1;
               end
            end
            OFFER: begin
               if (cand_ready) begin
                  state      <= FILL;
                  idx        <= '0;
                  cand_valid <= 1'b0;
                  cand_count <= cand_count + 32'd1;
`ifdef SMALL_PRIME_SIEVE_EN
                  residue    <= '0;
`endif
               end
            end
            default: state <= FILL;
         endcase
      end
   end

endmodule

// File: tb/tb_prime_candidate_builder.sv
// Bench for prime_candidate_builder: one 32-bit and one 64-bit instance, selected by sel, checked against a value-level model.
module tb_prime_candidate_builder;

   logic        clk = 1'b0;
   logic        reset, flush, enable, rand_valid, cand_ready, sel;
   logic [15:0] rand_in;

   logic [31:0] cand32, cc32, rc32;
   logic        cv32;
   logic [63:0] cand64;
   logic [31:0] cc64, rc64;
   logic        cv64;

   logic [63:0] cand_o;
   logic        cv_o;
   logic [31:0] cc_o, rc_o;

   int checks   = 0;
   int failures = 0;
   int exp_cc[2];
   int exp_rc[2];

`ifdef SMALL_PRIME_SIEVE_EN
   localparam bit SIEVE = 1'b1;
`else
   localparam bit SIEVE = 1'b0;
`endif

   always #5 clk = ~clk;

   prime_candidate_builder #(.WORDSIZE(32)) dut32 (
      .clk(clk), .reset(reset), .flush(flush & ~sel), .enable(enable & ~sel),
      .rand_in(rand_in), .rand_valid(rand_valid), .candidate(cand32), .cand_valid(cv32),
      .cand_ready(cand_ready & ~sel), .cand_count(cc32), .reject_count(rc32));

   prime_candidate_builder #(.WORDSIZE(64)) dut64 (
      .clk(clk), .reset(reset), .flush(flush & sel), .enable(enable & sel),
      .rand_in(rand_in), .rand_valid(rand_valid), .candidate(cand64), .cand_valid(cv64),
      .cand_ready(cand_ready & sel), .cand_count(cc64), .reject_count(rc64));

   always_comb begin
      if (sel) begin
         cand_o = cand64; cv_o = cv64; cc_o = cc64; rc_o = rc64;
      end else begin
         cand_o = {32'h0, cand32}; cv_o = cv32; cc_o = cc32; rc_o = rc32;
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic int nw_cur();
      return sel ? 4 : 2;
   endfunction

   // Candidate as a number: word k at bit 16k, low word odd, top two bits set.
   function automatic logic [63:0] model_value(input logic [15:0] w[4], input int nw);
      logic [63:0] v;
      logic [63:0] x;
      v = '0;
      for (int k = 0; k < nw; k++) begin
         x = 64'(w[k]);
         if (k == 0) x = x | 64'h1;
         if (k == nw - 1) x = x | 64'hC000;
         v = v | (x << (16 * k));
      end
      return v;
   endfunction

   function automatic bit model_pass(input logic [63:0] v);
      if (!SIEVE) return 1'b1;
      return !(((v % 3) == 0) || ((v % 5) == 0) || ((v % 17) == 0));
   endfunction

   task automatic pick_pass(output logic [15:0] w[4]);
      for (int t = 0; t < 1000; t++) begin
         for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
         if (model_pass(model_value(w, nw_cur()))) break;
      end
   endtask

   task automatic feed(input logic [15:0] w[4]);
      for (int k = 0; k < nw_cur(); k++) begin
         rand_in = w[k]; rand_valid = 1'b1; enable = 1'b1;
         tick();
      end
      rand_valid = 1'b0;
   endtask

   // Called right after the last word's capture edge.
   task automatic expect_result(input logic [15:0] w[4], input string tag, output bit p);
      logic [63:0] v;
      v = model_value(w, nw_cur());
      p = model_pass(v);
      chk({tag, ".cv_in_check"}, 64'(cv_o), 64'd0);
      tick();
      if (p) begin
         chk({tag, ".cv"}, 64'(cv_o), 64'd1);
         chk({tag, ".cand"}, cand_o, v);
      end else begin
         exp_rc[sel]++;
         chk({tag, ".cv_rej"}, 64'(cv_o), 64'd0);
      end
      chk({tag, ".rc"}, 64'(rc_o), 64'(exp_rc[sel]));
   endtask

   task automatic accept(input string tag);
      cand_ready = 1'b1;
      tick();
      exp_cc[sel]++;
      chk({tag, ".cv_after"}, 64'(cv_o), 64'd0);
      chk({tag, ".cc"}, 64'(cc_o), 64'(exp_cc[sel]));
      cand_ready = 1'b0;
   endtask

   initial begin
      logic [15:0] w[4];
      logic [15:0] w2[4];
      bit          p;
      logic [63:0] v;

      reset = 1'b1; flush = 1'b0; enable = 1'b0; rand_valid = 1'b0;
      cand_ready = 1'b0; sel = 1'b0; rand_in = '0;
      exp_cc = '{0, 0}; exp_rc = '{0, 0};
      #1 reset = 1'b0;
      #1;
      chk("rst.cand32", cand_o, 64'd0);
      chk("rst.cv32", 64'(cv_o), 64'd0);
      chk("rst.cc32", 64'(cc_o), 64'd0);
      chk("rst.rc32", 64'(rc_o), 64'd0);
      sel = 1'b1;
      #1;
      chk("rst.cand64", cand_o, 64'd0);
      chk("rst.cv64", 64'(cv_o), 64'd0);
      sel = 1'b0;
      #9 reset = 1'b1;
      tick();

      // Known vector: 0x1234, 0x0000 -> 0xC0001235 (residue 8)
      cand_ready = 1'b1;
      w = '{16'h1234, 16'h0000, 16'h0, 16'h0};
      feed(w);
      expect_result(w, "tp1", p);
      chk("tp1.const", cand_o, 64'hC000_1235);
      accept("tp1");
      chk("tp1.cc_const", 64'(cc_o), 64'd1);

      // 0x0002, 0x0000 -> 0xC0000003, a multiple of 3
      w = '{16'h0002, 16'h0000, 16'h0, 16'h0};
      feed(w);
      expect_result(w, "tp2", p);
`ifdef SMALL_PRIME_SIEVE_EN
      chk("tp2.rc_const", 64'(rc_o), 64'd1);
`else
      chk("tp2.cand_const", cand_o, 64'hC000_0003);
      chk("tp2.rc_const", 64'(rc_o), 64'd0);
      accept("tp2");
`endif

      // Words with enable=0 or rand_valid=0 are dropped mid-fill
      pick_pass(w);
      rand_in = w[0]; rand_valid = 1'b1; enable = 1'b1; tick();
      rand_in = 16'hFFFF; enable = 1'b0; tick();
      rand_valid = 1'b0; enable = 1'b1; tick();
      rand_in = w[1]; rand_valid = 1'b1; tick();
      rand_valid = 1'b0;
      expect_result(w, "drop", p);
      accept("drop");

      // Random candidates on both widths
      for (int i = 0; i < 10; i++) begin
         sel = i[0];
         for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
         feed(w);
         expect_result(w, "rnd", p);
         if (p) accept("rnd");
      end

      // Backpressure: offer held 5 cycles while words stream in
      sel = 1'b0;
      pick_pass(w);
      feed(w);
      expect_result(w, "bp", p);
      v = model_value(w, 2);
      for (int c = 0; c < 5; c++) begin
         rand_in = 16'($urandom); rand_valid = 1'b1; enable = 1'b1;
         tick();
         chk("bp.cv_hold", 64'(cv_o), 64'd1);
         chk("bp.cand_hold", cand_o, v);
         chk("bp.cc_hold", 64'(cc_o), 64'(exp_cc[0]));
      end
      rand_in = 16'($urandom);
      accept("bp");
      rand_valid = 1'b0;
      pick_pass(w2);
      feed(w2);
      expect_result(w2, "bp_next", p);
      accept("bp_next");

      // 64-bit flush after 2 of 4 words, with a word offered during the flush
      sel = 1'b1;
      for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
      rand_valid = 1'b1; enable = 1'b1;
      rand_in = w[0]; tick();
      rand_in = w[1]; tick();
      rand_in = 16'hA5A5; flush = 1'b1; tick();
      flush = 1'b0; rand_valid = 1'b0;
      pick_pass(w2);
      feed(w2);
      expect_result(w2, "flush_fill", p);
      accept("flush_fill");

      // Flush beats a simultaneous handshake
      pick_pass(w);
      feed(w);
      expect_result(w, "flush_hs", p);
      cand_ready = 1'b1; flush = 1'b1;
      tick();
      chk("flush_hs.cv", 64'(cv_o), 64'd0);
      chk("flush_hs.cc", 64'(cc_o), 64'(exp_cc[1]));
      flush = 1'b0; cand_ready = 1'b0;
      pick_pass(w2);
      feed(w2);
      expect_result(w2, "after_flush", p);
      accept("after_flush");

      // Async reset mid-OFFER
      sel = 1'b0;
      pick_pass(w);
      feed(w);
      expect_result(w, "rst_offer", p);
      reset = 1'b0;
      #1;
      chk("rst_offer.cand", cand_o, 64'd0);
      chk("rst_offer.cv", 64'(cv_o), 64'd0);
      chk("rst_offer.cc", 64'(cc_o), 64'd0);
      chk("rst_offer.rc", 64'(rc_o), 64'd0);
      exp_cc = '{0, 0}; exp_rc = '{0, 0};
      #1 reset = 1'b1;
      tick();

      // Async reset mid-FILL; first word afterwards lands in the low word
      for (int k = 0; k < 4; k++) w[k] = 16'($urandom);
      rand_in = w[0]; rand_valid = 1'b1; enable = 1'b1;
      tick();
      reset = 1'b0;
      #1;
      chk("rst_fill.cand", cand_o, 64'd0);
      #1 reset = 1'b1;
      pick_pass(w2);
      rand_in = w2[0];
      tick();
      chk("rst_fill.low_word", 64'(cand_o[15:0]), 64'(w2[0] | 16'h0001));
      rand_in = w2[1];
      tick();
      rand_valid = 1'b0;
      expect_result(w2, "rst_fill", p);
      accept("rst_fill");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/prime_candidate_builder.md
Name: prime_candidate_builder

Overview:
- Sits directly upstream of the Miller-Rabin tester in the key-generation path.
- Packs the rand127 16-bit output stream into a WORDSIZE-bit odd, top-heavy prime candidate and presents it with a valid/ready handshake.
- Decouples candidate assembly from the tester so the next candidate fills while the current one is being tested.
- Optionally discards candidates divisible by 3, 5 or 17 before they reach the tester.

Parameters:
- WORDSIZE, 256: candidate width in bits. Must be a multiple of 16 and at least 32. NWORDS = WORDSIZE/16 is a derived localparam.

Ports:
- clk  in  1  single clock domain, rising edge.
- reset  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous abort of the current candidate.
- enable  in  1  permits consumption of random words.
- rand_in  in  16  random word from the PRNG.
- rand_valid  in  1  rand_in holds a fresh word this cycle.
- candidate  out  WORDSIZE  assembled candidate.
- cand_valid  out  1  candidate is stable and offered.
- cand_ready  in  1  tester accepts candidate.
- cand_count  out  32  number of candidates handed off.
- reject_count  out  32  number of candidates rejected by the sieve.

Behaviour:
- Reset (reset=0, async): state=FILL, word index=0, residue=0; candidate=0, cand_valid=0, cand_count=0, reject_count=0.
- States: FILL, CHECK, OFFER.
- FILL, capture rule: a word is captured when rand_valid && enable. Word k (k=0..NWORDS-1) is written to candidate[16k+15:16k]; the low word fills first.
- FILL, bit forcing: forcing is applied to the word as it is written.
  - word 0 is ORed with 0x0001 (odd);
  - word NWORDS-1 is ORed with 0xC000 (top two bits set, so p*q keeps full width).
- FILL, words outside the capture rule: words with enable=0 are dropped, and the partial candidate is retained.
- FILL exit: the capture of word NWORDS-1 moves the FSM to CHECK on the next cycle.
- Residue: an 8-bit running sum mod 255 of the forced words. 2^16 ≡ 1 (mod 255), so this equals candidate mod 255. Fold form: r' = (r + hi + lo) mod 255. It is cleared when a new candidate starts.
- CHECK: exactly 1 cycle. Pass → OFFER. Reject (sieve enabled only) → FILL with index=0, residue=0, and reject_count increments.
- OFFER:
  - cand_valid=1; candidate is held stable until cand_valid && cand_ready.
  - On that transfer: cand_count increments, cand_valid=0 the next cycle, and the FSM returns to FILL with index=0.
- Rand words in CHECK/OFFER: ignored (never buffered).
- Latency: last word captured → cand_valid high 2 clocks later (capture edge, CHECK edge). Minimum candidate period is NWORDS+2 cycles.
- flush=1: has priority over all other events, including a simultaneous handshake.
  - Next state FILL, index=0, residue=0, cand_valid=0.
  - No counter increments.
  - The candidate register keeps stale data; this is permitted because cand_valid=0.
- Counters wrap modulo 2^32.
- cand_ready while cand_valid=0 has no effect.
- reset asserted mid-operation: immediate return to reset values.

Optional Feature:
- Macro: SMALL_PRIME_SIEVE_EN.
- Defined: CHECK rejects when (residue mod 3)==0, (residue mod 5)==0 or (residue mod 17)==0. Residues 0 and 255 are both treated as 0.
- Not defined: the residue logic is absent, CHECK always passes (still 1 cycle, so latency is identical), and reject_count is tied to 0.

Test Plan:
- WORDSIZE=32, sieve on, cand_ready=1; words 0x1234, 0x0000 → candidate=0xC0001235 (residue 8), cand_valid 2 cycles after second word, cand_count=1.
- WORDSIZE=32, sieve on; words 0x0002, 0x0000 → forced 0xC0000003 (residue 195, divisible by 3) is rejected: cand_valid stays 0, reject_count=1; the FSM refills from the next word.
- Same as previous with macro undefined → cand_valid with candidate=0xC0000003, reject_count=0.
- Backpressure, WORDSIZE=32:
  - Stimulus: candidate offered, cand_ready held 0 for 5 cycles while rand_valid=1 every cycle, then cand_ready=1.
  - Response: candidate and cand_valid held stable and no words consumed during the stall; one transfer; next candidate built only from words arriving after the transfer.
- WORDSIZE=64, sieve on:
  - flush after 2 of 4 words → index restarts; the next 4 words alone form the candidate.
  - flush coinciding with cand_valid&&cand_ready → no cand_count increment.
- Async reset pulse mid-OFFER and mid-FILL → all outputs return to 0 immediately; the first post-reset word lands in candidate[15:0].
